sched_lectura: RTL and testbench
================================

# sched_lectura

Sampling scheduler and decision controller for the temperature-monitoring path. It periodically requests a reading from the sensor interface and captures the returned sample. It applies threshold hysteresis with consecutive-sample confirmation and drives the `ac_ventilador` / `ac_alarma` requests consumed by the fan/alarm FSM. A sensor that fails to answer is detected and forced into a safe state.

## Interface
- `DATA_W`, 8: sample width, unsigned.
- `PERIOD`, 1000: clock cycles between sample requests (≥ 4).
- `TIMEOUT`, 255: max cycles waiting for `sens_done` after `sens_start`.
- `FAN_ON`, 30 / `FAN_OFF`, 27: fan set / clear thresholds (`FAN_OFF` < `FAN_ON`).
- `ALM_ON`, 45 / `ALM_OFF`, 40: alarm set / clear thresholds (`ALM_OFF` < `ALM_ON`).
- `CONFIRM`, 3: consecutive qualifying samples needed to change an output (1..15).
- Clock: `clk` only. Reset: `rst`, synchronous, active-low.
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-low reset.
- `en` in 1: scheduler enable.
- `sens_done` in 1: sample valid from sensor, one-cycle pulse.
- `sens_data` in DATA_W: sample, valid when `sens_done`=1.
- `alarm_clr` in 1: alarm acknowledge, used only with `ALARM_LATCH_EN`.
- `sens_start` out 1: one-cycle read request.
- `lectura` out 1: one-cycle pulse, the sample was accepted and evaluated.
- `temp_q` out DATA_W: last accepted sample.
- `ac_ventilador` out 1: fan request.
- `ac_alarma` out 1: alarm request.
- `fault` out 1: sensor timeout, sticky.
- `estado` out 2: current FSM state encoding.

## Operation
- All outputs reset to 0. The FSM resets to IDLE and all counters reset to 0.
- States (`estado`):
  - IDLE=00: waiting for `en`=1; goes to WAIT_TICK.
  - WAIT_TICK=01: period timer runs; on tick, pulse `sens_start` and go to WAIT_DONE.
  - WAIT_DONE=10: on `sens_done`, capture `sens_data` into `temp_q` and go to EVAL. If TIMEOUT cycles elapse first, set `fault` and go to WAIT_TICK.
  - EVAL=11: update hysteresis counters and outputs, pulse `lectura`, go to WAIT_TICK.
- Fan hysteresis: a sample ≥ `FAN_ON` increments the on-counter and clears the off-counter. A sample < `FAN_OFF` increments the off-counter and clears the on-counter. A sample in between clears both counters. The on-counter reaching `CONFIRM` sets `ac_ventilador`; the off-counter reaching `CONFIRM` clears it. Counters saturate at `CONFIRM`.
- The alarm uses identical logic with its own counters and `ALM_ON` / `ALM_OFF`.
- Comparisons are unsigned and use the full `DATA_W` width.
- Fault behaviour: while `fault`=1, `ac_ventilador` and `ac_alarma` are forced to 1. Sampling continues. A later valid sample does not clear `fault`. Only reset or `en`=0 clears it.
- `en`=0 in any state: next cycle IDLE; timer, counters, `fault`, `ac_ventilador` and `ac_alarma` cleared. `temp_q` holds its value.
- `en`=0 together with `sens_done`: `en` wins and the sample is discarded.
- A `sens_done` that arrives outside WAIT_DONE is ignored.
- Reset mid-operation behaves exactly like power-up reset.

## Timing
- The period timer starts on entry to WAIT_TICK from IDLE. First `sens_start` comes PERIOD cycles after `en` is sampled high.
- The timer free-runs from then on, so ticks are PERIOD cycles apart regardless of sensor latency.
- A tick that arrives while not in WAIT_TICK is dropped; the next request waits for the following tick.
- `sens_done` at cycle N: `temp_q` valid at N+1, `lectura` high during N+1 (EVAL), `ac_*` updated at N+2.
- Timeout: `sens_done` not seen within TIMEOUT cycles after `sens_start` → `fault` high on the next edge.
- A `sens_done` in the same cycle the timeout expires is accepted and no fault is raised.

## Configuration
- `ALARM_LATCH_EN` defined: once `ac_alarma` sets, it stays set until `alarm_clr`=1 and the alarm off-counter has reached `CONFIRM`. `alarm_clr` while still hot has no effect.
- `ALARM_LATCH_EN` undefined: the alarm clears automatically through hysteresis and `alarm_clr` is ignored.

## Structure
- Shared package/header holds:
  - state encodings `ST_IDLE`, `ST_WAIT_TICK`, `ST_WAIT_DONE`, `ST_EVAL`, which the fan/alarm FSM also reads through `estado`;
  - default threshold constants.
- One sub-module, `tick_gen`: PERIOD-cycle down-counter with sync clear, emitting a one-cycle `tick`.
- Hysteresis is instantiated twice as repeated logic, not as a module.

## Test plan
Bench overrides: PERIOD=8, TIMEOUT=5, CONFIRM=3.
- Reset with `en`=1: all outputs 0, `estado`=00. After release, the first `sens_start` arrives 8 cycles later.
- Sensor answers 2 cycles after each request with 31, 31, 31: `ac_ventilador` rises 1 cycle after the third `lectura`. Then 28, 26, 26, 26: it stays high through 28 and clears after the third 26.
- Samples 46, 46, 20, 46, 46: `ac_alarma` stays 0 because the confirmation streak is broken by 20.
- No `sens_done` after `sens_start`: `fault`=1 after 5 cycles and both `ac_*`=1. A later valid sample of 10 leaves `fault`=1. Pulsing `en` low clears everything.
- `en` dropped in the same cycle as `sens_done`=1 with data 99: `temp_q` unchanged, `estado`=00 next cycle.
- With `ALARM_LATCH_EN`: after 3×50, then 3×30, `ac_alarma` stays 1. `alarm_clr` pulse → 0. `alarm_clr` pulsed while samples are at 50 → stays 1.

Source files
------------

// File: rtl/sched_lectura_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sched_lectura_pkg                                          |
// | Description : Shared definitions for the temperature sampling scheduler. |
// |               Holds the state encodings (also decoded by the fan/alarm   |
// |               FSM through `estado`), the default thresholds and a        |
// |               saturating-increment helper for the confirmation counters. |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package sched_lectura_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_TICK = 2'b01,
    ST_WAIT_DONE = 2'b10,
    ST_EVAL      = 2'b11
  } state_t;

  // Default configuration
  localparam int c_DEF_DATA_W  = 8;
  localparam int c_DEF_PERIOD  = 1000;
  localparam int c_DEF_TIMEOUT = 255;
  localparam int c_DEF_FAN_ON  = 30;
  localparam int c_DEF_FAN_OFF = 27;
  localparam int c_DEF_ALM_ON  = 45;
  localparam int c_DEF_ALM_OFF = 40;
  localparam int c_DEF_CONFIRM = 3;

  // Confirmation counters hold at most 15
  localparam int c_CNT_W = 4;

  function automatic logic [c_CNT_W-1:0] sat_inc(
    input logic [c_CNT_W-1:0] cnt,
    input logic [c_CNT_W-1:0] lim
  );
    return (cnt >= lim) ? lim : cnt + c_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sched_lectura_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tick_gen                                                   |
// | Description : PERIOD-cycle down-counter with synchronous clear. Emits a  |
// |               one-cycle tick every PERIOD cycles after clear is released.|
// | Ports       : clk  in  - system clock                                    |
// |               rst  in  - synchronous active-low reset                    |
// |               clr  in  - synchronous restart of the period               |
// |               tick out - one-cycle pulse at the end of each period       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tick_gen #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int                 c_W      = $clog2(PERIOD);
  localparam logic [c_W-1:0]     c_RELOAD = c_W'(PERIOD - 1);

  logic [c_W-1:0] r_cnt;

  // While clr is held the counter sits at PERIOD-1, so the first tick
  // appears PERIOD cycles after the first cycle with clr low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == '0)) begin
      r_cnt <= c_RELOAD;
    end else begin
      r_cnt <= r_cnt - c_W'(1);
    end
  end

  assign tick = (r_cnt == '0) && !clr;

endmodule
`default_nettype wire

// File: rtl/sched_lectura.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sched_lectura                                              |
// | Description : Sampling scheduler and decision controller. Requests a     |
// |               sensor reading every PERIOD cycles, captures the sample,   |
// |               runs fan and alarm threshold hysteresis with CONFIRM-deep  |
// |               consecutive-sample confirmation and flags a silent sensor  |
// |               as a sticky fault that forces both requests on.            |
// | Ports       : clk, rst(active-low sync), en, sens_done, sens_data,       |
// |               alarm_clr -> sens_start, lectura, temp_q, ac_ventilador,   |
// |               ac_alarma, fault, estado                                   |
// | Config      : ALARM_LATCH_EN - alarm stays set until alarm_clr while     |
// |               the alarm off-counter is confirmed                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sched_lectura
  import sched_lectura_pkg::*;
#(
  parameter int DATA_W  = c_DEF_DATA_W,
  parameter int PERIOD  = c_DEF_PERIOD,
  parameter int TIMEOUT = c_DEF_TIMEOUT,
  parameter int FAN_ON  = c_DEF_FAN_ON,
  parameter int FAN_OFF = c_DEF_FAN_OFF,
  parameter int ALM_ON  = c_DEF_ALM_ON,
  parameter int ALM_OFF = c_DEF_ALM_OFF,
  parameter int CONFIRM = c_DEF_CONFIRM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sens_done,
  input  logic [DATA_W-1:0] sens_data,
  input  logic              alarm_clr,
  output logic              sens_start,
  output logic              lectura,
  output logic [DATA_W-1:0] temp_q,
  output logic              ac_ventilador,
  output logic              ac_alarma,
  output logic              fault,
  output logic [1:0]        estado
);

  localparam int                  c_TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST = c_TO_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0]  c_CONF    = c_CNT_W'(CONFIRM);
  localparam logic [DATA_W-1:0]   c_FAN_ON  = DATA_W'(FAN_ON);
  localparam logic [DATA_W-1:0]   c_FAN_OFF = DATA_W'(FAN_OFF);
  localparam logic [DATA_W-1:0]   c_ALM_ON  = DATA_W'(ALM_ON);
  localparam logic [DATA_W-1:0]   c_ALM_OFF = DATA_W'(ALM_OFF);

  state_t              r_state, w_state_nx;
  logic                w_tick, w_tick_clr, w_timeout;
  logic [c_TO_W-1:0]   r_wait;
  logic [DATA_W-1:0]   r_temp_q;
  logic                r_sens_start, r_fault, r_fan, r_alm;
  logic [c_CNT_W-1:0]  r_fan_on, r_fan_off, r_alm_on, r_alm_off;
  logic [c_CNT_W-1:0]  w_fan_on_nx, w_fan_off_nx, w_alm_on_nx, w_alm_off_nx;
  logic                w_fan_nx, w_alm_nx, w_alm_set, w_alm_clr, w_eval;

  // Timer restarts whenever the scheduler is idle or disabled, then free-runs
  assign w_tick_clr = (r_state == ST_IDLE) || !en;

  tick_gen #(.PERIOD(PERIOD)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_tick_clr),
    .tick (w_tick)
  );

  // ---------------------------------------------------------------- FSM --
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_timeout  = 1'b0;
    if (!en) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      w_state_nx = ST_WAIT_TICK;
        ST_WAIT_TICK: if (w_tick) w_state_nx = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          // A sample in the last allowed cycle still wins over the timeout
          if (sens_done) begin
            w_state_nx = ST_EVAL;
          end else if (r_wait == c_TO_LAST) begin
            w_timeout  = 1'b1;
            w_state_nx = ST_WAIT_TICK;
          end
        end
        ST_EVAL:      w_state_nx = ST_WAIT_TICK;
        default:      w_state_nx = ST_IDLE;
      endcase
    end
    lectura = (r_state == ST_EVAL) && en;
  end

  assign w_eval = (r_state == ST_EVAL);

  // --------------------------------------------------------- hysteresis --
  always_comb begin
    w_fan_on_nx  = r_fan_on;
    w_fan_off_nx = r_fan_off;
    w_alm_on_nx  = r_alm_on;
    w_alm_off_nx = r_alm_off;
    w_fan_nx     = r_fan;
    w_alm_nx     = r_alm;

    if (w_eval) begin
      // Fan channel
      if (r_temp_q >= c_FAN_ON) begin
        w_fan_on_nx  = sat_inc(r_fan_on, c_CONF);
        w_fan_off_nx = '0;
      end else if (r_temp_q < c_FAN_OFF) begin
        w_fan_off_nx = sat_inc(r_fan_off, c_CONF);
        w_fan_on_nx  = '0;
      end else begin
        w_fan_on_nx  = '0;
        w_fan_off_nx = '0;
      end
      if (w_fan_on_nx == c_CONF) begin
        w_fan_nx = 1'b1;
      end else if (w_fan_off_nx == c_CONF) begin
        w_fan_nx = 1'b0;
      end

      // Alarm channel
      if (r_temp_q >= c_ALM_ON) begin
        w_alm_on_nx  = sat_inc(r_alm_on, c_CONF);
        w_alm_off_nx = '0;
      end else if (r_temp_q < c_ALM_OFF) begin
        w_alm_off_nx = sat_inc(r_alm_off, c_CONF);
        w_alm_on_nx  = '0;
      end else begin
        w_alm_on_nx  = '0;
        w_alm_off_nx = '0;
      end
    end

    w_alm_set = w_eval && (w_alm_on_nx == c_CONF);
`ifdef ALARM_LATCH_EN
    // Latched: the acknowledge may come in any cycle, but only once the
    // temperature has been confirmed cool.
    w_alm_clr = alarm_clr && (w_alm_off_nx == c_CONF);
`else
    w_alm_clr = w_eval && (w_alm_off_nx == c_CONF);
`endif
    if (w_alm_set) begin
      w_alm_nx = 1'b1;
    end else if (w_alm_clr) begin
      w_alm_nx = 1'b0;
    end
  end

`ifndef ALARM_LATCH_EN
  logic w_unused_alarm_clr;
  assign w_unused_alarm_clr = alarm_clr;
`endif

  // ----------------------------------------------------------- datapath --
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sens_start <= 1'b0;
      r_wait       <= '0;
      r_temp_q     <= '0;
      r_fault      <= 1'b0;
      r_fan        <= 1'b0;
      r_alm        <= 1'b0;
      r_fan_on     <= '0;
      r_fan_off    <= '0;
      r_alm_on     <= '0;
      r_alm_off    <= '0;
    end else if (!en) begin
      // Disable clears the decision state; the last sample is kept
      r_sens_start <= 1'b0;
      r_wait       <= '0;
      r_fault      <= 1'b0;
      r_fan        <= 1'b0;
      r_alm        <= 1'b0;
      r_fan_on     <= '0;
      r_fan_off    <= '0;
      r_alm_on     <= '0;
      r_alm_off    <= '0;
    end else begin
      r_sens_start <= (r_state == ST_WAIT_TICK) && w_tick;
      r_wait       <= (r_state == ST_WAIT_DONE) ? r_wait + c_TO_W'(1) : '0;
      if ((r_state == ST_WAIT_DONE) && sens_done) begin
        r_temp_q <= sens_data;
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
      r_fan     <= w_fan_nx;
      r_alm     <= w_alm_nx;
      r_fan_on  <= w_fan_on_nx;
      r_fan_off <= w_fan_off_nx;
      r_alm_on  <= w_alm_on_nx;
      r_alm_off <= w_alm_off_nx;
    end
  end

  assign sens_start    = r_sens_start;
  assign temp_q        = r_temp_q;
  assign fault         = r_fault;
  assign ac_ventilador = r_fan | r_fault;
  assign ac_alarma     = r_alm | r_fault;
  assign estado        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sched_lectura.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sched_lectura                                           |
// | Description : Directed testbench for sched_lectura with PERIOD=8,        |
// |               TIMEOUT=5, CONFIRM=3 and hand-computed expectations.       |
// | Config      : ALARM_LATCH_EN selects the latched-alarm sequence          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sched_lectura;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       en        = 1'b0;
  logic       sens_done = 1'b0;
  logic [7:0] sens_data = 8'd0;
  logic       alarm_clr = 1'b0;
  logic       sens_start, lectura, ac_ventilador, ac_alarma, fault;
  logic [7:0] temp_q;
  logic [1:0] estado;

  int   n_checks = 0;
  int   n_errors = 0;
  logic e_fan    = 1'b0;
  logic e_alm    = 1'b0;
  logic [7:0] e_temp = 8'd0;

  always #5 clk = ~clk;

  sched_lectura #(
    .DATA_W (8),
    .PERIOD (8),
    .TIMEOUT(5),
    .FAN_ON (30),
    .FAN_OFF(27),
    .ALM_ON (45),
    .ALM_OFF(40),
    .CONFIRM(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sens_done    (sens_done),
    .sens_data    (sens_data),
    .alarm_clr    (alarm_clr),
    .sens_start   (sens_start),
    .lectura      (lectura),
    .temp_q       (temp_q),
    .ac_ventilador(ac_ventilador),
    .ac_alarma    (ac_alarma),
    .fault        (fault),
    .estado       (estado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      seen = sens_start;
    end
    if (!seen) check("start_timeout", 32'd0, 32'd1);
  endtask

  // Sensor replies in the second cycle after the request
  task automatic answer(input logic [7:0] d, input logic fan_after, input logic alm_after);
    step();
    sens_done = 1'b1;
    sens_data = d;
    step();
    sens_done = 1'b0;
    check("lectura", lectura, 1);
    check("temp_q", temp_q, d);
    check("fan_hold", ac_ventilador, e_fan);
    check("alm_hold", ac_alarma, e_alm);
    e_fan  = fan_after;
    e_alm  = alm_after;
    e_temp = d;
    step();
    check("lectura_off", lectura, 0);
    check("estado_wt", estado, 2'b01);
    check("fan", ac_ventilador, e_fan);
    check("alm", ac_alarma, e_alm);
  endtask

  task automatic do_sample(input logic [7:0] d, input logic fan_after, input logic alm_after);
    int n;
    wait_start(n);
    answer(d, fan_after, alm_after);
  endtask

  task automatic en_pulse();
    en = 1'b0;
    step();
    check("dis_estado", estado, 2'b00);
    check("dis_fault", fault, 0);
    check("dis_fan", ac_ventilador, 0);
    check("dis_alm", ac_alarma, 0);
    check("dis_temp", temp_q, e_temp);
    e_fan = 1'b0;
    e_alm = 1'b0;
    en    = 1'b1;
    step();
    check("ren_estado", estado, 2'b01);
  endtask

  task automatic pulse_clr();
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int k;

    // Reset held with en high
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) step();
    check("rst_start", sens_start, 0);
    check("rst_lectura", lectura, 0);
    check("rst_temp", temp_q, 0);
    check("rst_fan", ac_ventilador, 0);
    check("rst_alm", ac_alarma, 0);
    check("rst_fault", fault, 0);
    check("rst_estado", estado, 2'b00);
    rst = 1'b1;
    step();
    check("first_estado", estado, 2'b01);
    wait_start(n);
    check("first_start", n, 8);

    // Fan set / hold / clear
    answer(8'd31, 1'b0, 1'b0);
    do_sample(8'd31, 1'b0, 1'b0);
    do_sample(8'd31, 1'b1, 1'b0);
    do_sample(8'd28, 1'b1, 1'b0);
    do_sample(8'd26, 1'b1, 1'b0);
    do_sample(8'd26, 1'b1, 1'b0);
    do_sample(8'd26, 1'b0, 1'b0);

    // Broken alarm streak
    do_sample(8'd46, 1'b0, 1'b0);
    do_sample(8'd46, 1'b0, 1'b0);
    do_sample(8'd20, 1'b0, 1'b0);
    do_sample(8'd46, 1'b0, 1'b0);
    do_sample(8'd46, 1'b0, 1'b0);

    en_pulse();

`ifdef ALARM_LATCH_EN
    do_sample(8'd50, 1'b0, 1'b0);
    do_sample(8'd50, 1'b0, 1'b0);
    do_sample(8'd50, 1'b1, 1'b1);
    do_sample(8'd30, 1'b1, 1'b1);
    do_sample(8'd30, 1'b1, 1'b1);
    do_sample(8'd30, 1'b1, 1'b1);
    pulse_clr();
    check("latch_clr", ac_alarma, 0);
    e_alm = 1'b0;
    do_sample(8'd50, 1'b1, 1'b0);
    do_sample(8'd50, 1'b1, 1'b0);
    do_sample(8'd50, 1'b1, 1'b1);
    pulse_clr();
    check("latch_hot_clr", ac_alarma, 1);
`else
    do_sample(8'd50, 1'b0, 1'b0);
    do_sample(8'd50, 1'b0, 1'b0);
    do_sample(8'd50, 1'b1, 1'b1);
    do_sample(8'd30, 1'b1, 1'b1);
    do_sample(8'd30, 1'b1, 1'b1);
    pulse_clr();
    check("clr_ignored", ac_alarma, 1);
    do_sample(8'd30, 1'b1, 1'b0);
`endif

    en_pulse();

    // Silent sensor
    wait_start(n);
    check("restart_start", n, 8);
    k = 0;
    while (!fault && k < 20) begin
      step();
      k++;
    end
    check("fault_latency", k, 5);
    check("fault_fan", ac_ventilador, 1);
    check("fault_alm", ac_alarma, 1);
    check("fault_estado", estado, 2'b01);
    e_fan = 1'b1;
    e_alm = 1'b1;
    do_sample(8'd10, 1'b1, 1'b1);
    check("fault_sticky", fault, 1);

    // Stray sens_done while waiting for the tick
    sens_done = 1'b1;
    sens_data = 8'd77;
    step();
    sens_done = 1'b0;
    check("stray_temp", temp_q, 10);
    check("stray_lectura", lectura, 0);

    en_pulse();

    // Disable coinciding with a sample
    wait_start(n);
    step();
    sens_done = 1'b1;
    sens_data = 8'd99;
    en        = 1'b0;
    step();
    sens_done = 1'b0;
    check("drop_temp", temp_q, 10);
    check("drop_estado", estado, 2'b00);
    check("drop_lectura", lectura, 0);
    en = 1'b1;

    // Reset in the middle of operation
    repeat (3) step();
    rst = 1'b0;
    step();
    check("mid_rst_estado", estado, 2'b00);
    check("mid_rst_temp", temp_q, 0);
    check("mid_rst_fault", fault, 0);
    rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
